// File: rtl/simple_risc_core_pkg.sv
// Shared definitions for the simple 16-bit RISC core: widths, instruction
// field positions and opcode encoding.
package simple_risc_core_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 8;
  localparam int REG_N  = 8;
  localparam int REG_AW = $clog2(REG_N);

  localparam int OP_MSB = 15;
  localparam int OP_LSB = 12;
  localparam int RD_MSB = 11;
  localparam int RD_LSB = 9;
  localparam int RS_MSB = 8;
  localparam int RS_LSB = 6;
  localparam int RT_MSB = 5;
  localparam int RT_LSB = 3;
  localparam int IMM6_W = 6;
  localparam int IMM8_W = 8;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_XOR  = 4'h5,
    OP_SLT  = 4'h6,
    OP_ADDI = 4'h7,
    OP_LI   = 4'h8,
    OP_LD   = 4'h9,
    OP_ST   = 4'hA,
    OP_BEQ  = 4'hB,
    OP_BNE  = 4'hC,
    OP_JMP  = 4'hD,
    OP_RSVD = 4'hE,
    OP_HALT = 4'hF
  } opcode_e;

  function automatic logic [DATA_W-1:0] sext_imm6(input logic [IMM6_W-1:0] imm);
    return {{(DATA_W-IMM6_W){imm[IMM6_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/simple_risc_core_alu.sv
// Combinational ALU for the register-register operations; any other opcode
// yields zero.
module risc_alu
  import simple_risc_core_pkg::*;
(
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  opcode_e           i_op,
  output logic [DATA_W-1:0] o_result
);

  always_comb begin
    o_result = '0;
    case (i_op)
      OP_ADD:  o_result = i_a + i_b;
      OP_SUB:  o_result = i_a - i_b;
      OP_AND:  o_result = i_a & i_b;
      OP_OR:   o_result = i_a | i_b;
      OP_XOR:  o_result = i_a ^ i_b;
      OP_SLT:  o_result = {{(DATA_W-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/simple_risc_core.sv
// Single-cycle 16-bit RISC core: decode, register file, memories and pc.
// State is observed hierarchically through pc, regs, dmem and halted.
module simple_risc_core
  import simple_risc_core_pkg::*;
#(
  parameter string IMEM_FILE = "imem.hex",
  parameter string DMEM_FILE = ""
)
(
  input logic clk,
  input logic rst
);

  logic [ADDR_W-1:0] pc;
  logic              halted;
  logic [DATA_W-1:0] regs [0:REG_N-1];
  logic [DATA_W-1:0] imem [0:(2**ADDR_W)-1];
  logic [DATA_W-1:0] dmem [0:(2**ADDR_W)-1];

  // Memories start cleared; contents are set hierarchically.
  initial begin
    for (int i = 0; i < 2**ADDR_W; i++) begin
      imem[i] = '0;
      dmem[i] = '0;
    end
  end

  logic [DATA_W-1:0] w_instr;
  opcode_e           w_op;
  logic [REG_AW-1:0] w_rd, w_rs, w_rt;
  logic [DATA_W-1:0] w_rd_val, w_rs_val, w_rt_val;
  logic [DATA_W-1:0] w_simm, w_alu_res, w_wr_data;
  logic [ADDR_W-1:0] w_ea, w_pc_inc, w_pc_next;
  logic              w_reg_we, w_mem_we, w_halt;

  assign w_instr  = imem[pc];
  assign w_op     = opcode_e'(w_instr[OP_MSB:OP_LSB]);
  assign w_rd     = w_instr[RD_MSB:RD_LSB];
  assign w_rs     = w_instr[RS_MSB:RS_LSB];
  assign w_rt     = w_instr[RT_MSB:RT_LSB];
  assign w_rd_val = (w_rd == '0) ? '0 : regs[w_rd];
  assign w_rs_val = (w_rs == '0) ? '0 : regs[w_rs];
  assign w_rt_val = (w_rt == '0) ? '0 : regs[w_rt];
  assign w_simm   = sext_imm6(w_instr[IMM6_W-1:0]);
  // Effective address only needs the low byte of rs+imm6.
  assign w_ea     = w_rs_val[ADDR_W-1:0] + w_simm[ADDR_W-1:0];
  assign w_pc_inc = pc + ADDR_W'(1);

  risc_alu u_alu (
    .i_a      (w_rs_val),
    .i_b      (w_rt_val),
    .i_op     (w_op),
    .o_result (w_alu_res)
  );

  always_comb begin
    w_pc_next = w_pc_inc;
    w_reg_we  = 1'b0;
    w_mem_we  = 1'b0;
    w_halt    = 1'b0;
    w_wr_data = w_alu_res;
    case (w_op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT: w_reg_we = 1'b1;
      OP_ADDI: begin
        w_reg_we  = 1'b1;
        w_wr_data = w_rs_val + w_simm;
      end
      OP_LI: begin
        w_reg_we  = 1'b1;
        w_wr_data = {{(DATA_W-IMM8_W){1'b0}}, w_instr[IMM8_W-1:0]};
      end
      OP_LD: begin
        w_reg_we  = 1'b1;
        w_wr_data = dmem[w_ea];
      end
      OP_ST:  w_mem_we = 1'b1;
      OP_BEQ: if (w_rd_val == w_rs_val) w_pc_next = w_pc_inc + w_simm[ADDR_W-1:0];
      OP_BNE: if (w_rd_val != w_rs_val) w_pc_next = w_pc_inc + w_simm[ADDR_W-1:0];
      OP_JMP: w_pc_next = w_instr[ADDR_W-1:0];
      OP_HALT: begin
        w_halt    = 1'b1;
        w_pc_next = pc;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc     <= '0;
      halted <= 1'b0;
      for (int i = 0; i < REG_N; i++) regs[i] <= '0;
    end else if (!halted) begin
      pc <= w_pc_next;
      if (w_halt) halted <= 1'b1;
      if (w_reg_we && (w_rd != '0)) regs[w_rd] <= w_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !halted && w_mem_we) dmem[w_ea] <= w_rd_val;
  end

endmodule

// File: tb/tb_simple_risc_core.sv
// Self-checking bench: an instruction-level interpreter tracks the expected
// architectural state and is compared with the core after every clock edge.
module tb_simple_risc_core;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  simple_risc_core #(.IMEM_FILE(""), .DMEM_FILE("")) dut (
    .clk (clk),
    .rst (rst)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  logic [15:0] m_imem [256];
  logic [15:0] m_dmem [256];
  logic [15:0] m_regs [8];
  logic [7:0]  m_pc;
  logic        m_halt;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [15:0] enc_r(input logic [3:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs, input logic [2:0] rt);
    return {op, rd, rs, rt, 3'b000};
  endfunction

  function automatic logic [15:0] enc_i(input logic [3:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs, input logic [5:0] imm);
    return {op, rd, rs, imm};
  endfunction

  function automatic logic [15:0] enc_l(input logic [3:0] op, input logic [2:0] rd,
                                        input logic [7:0] imm);
    return {op, rd, 1'b0, imm};
  endfunction

  // Interpreter for one rising edge, written from the instruction semantics.
  task automatic model_edge();
    logic [15:0] ins, a, b, d, simm;
    logic [3:0]  op;
    logic [2:0]  rd, rs, rt;
    logic [7:0]  ea, nxt;
    if (rst) begin
      m_pc = 8'h00;
      m_halt = 1'b0;
      for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
      return;
    end
    if (m_halt) return;
    ins  = m_imem[m_pc];
    op   = ins[15:12];
    rd   = ins[11:9];
    rs   = ins[8:6];
    rt   = ins[5:3];
    a    = m_regs[rs];
    b    = m_regs[rt];
    d    = m_regs[rd];
    simm = {{10{ins[5]}}, ins[5:0]};
    ea   = 8'(a + simm);
    nxt  = 8'(m_pc + 8'd1);
    case (op)
      4'h1: if (rd != 0) m_regs[rd] = a + b;
      4'h2: if (rd != 0) m_regs[rd] = a - b;
      4'h3: if (rd != 0) m_regs[rd] = a & b;
      4'h4: if (rd != 0) m_regs[rd] = a | b;
      4'h5: if (rd != 0) m_regs[rd] = a ^ b;
      4'h6: if (rd != 0) m_regs[rd] = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
      4'h7: if (rd != 0) m_regs[rd] = a + simm;
      4'h8: if (rd != 0) m_regs[rd] = {8'h00, ins[7:0]};
      4'h9: if (rd != 0) m_regs[rd] = m_dmem[ea];
      4'hA: m_dmem[ea] = d;
      4'hB: if (d == a) nxt = 8'(m_pc + 8'd1 + simm[7:0]);
      4'hC: if (d != a) nxt = 8'(m_pc + 8'd1 + simm[7:0]);
      4'hD: nxt = ins[7:0];
      4'hF: begin
        m_halt = 1'b1;
        nxt = m_pc;
      end
      default: ;
    endcase
    m_pc = nxt;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
    end
  endtask

  task automatic set_imem(input int addr, input logic [15:0] w);
    dut.imem[8'(addr)] = w;
    m_imem[8'(addr)]   = w;
  endtask

  // Holds reset while the caller loads a new program image of NOPs.
  task automatic begin_prog();
    rst = 1'b1;
    for (int i = 0; i < 256; i++) set_imem(i, 16'h0000);
  endtask

  task automatic start_prog();
    tick(2);
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check("pc", {8'h00, dut.pc}, {8'h00, m_pc});
      check("halted", 16'(dut.halted), 16'(m_halt));
      for (int i = 0; i < 8; i++)
        check($sformatf("r%0d", i), dut.regs[3'(i)], m_regs[i]);
    end
  end

  initial begin
    int cyc;
    logic [15:0] w;

    for (int i = 0; i < 256; i++) m_dmem[i] = 16'h0000;
    m_pc = 8'h00;
    m_halt = 1'b0;
    for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;

    // Reset held for two edges clears pc and registers.
    begin_prog();
    start_prog();
    chk_on = 1'b1;
    check("rst_pc", {8'h00, dut.pc}, 16'h0000);
    check("rst_halted", 16'(dut.halted), 16'h0000);
    for (int i = 0; i < 8; i++) check($sformatf("rst_r%0d", i), dut.regs[3'(i)], 16'h0000);
    $display("reset: pc=%0h", dut.pc);

    // ALU program; the leading NOP puts HALT at address 6.
    begin_prog();
    set_imem(1, enc_l(4'h8, 3'd1, 8'd5));
    set_imem(2, enc_l(4'h8, 3'd2, 8'd3));
    set_imem(3, enc_r(4'h1, 3'd3, 3'd1, 3'd2));
    set_imem(4, enc_r(4'h2, 3'd4, 3'd2, 3'd1));
    set_imem(5, enc_r(4'h6, 3'd5, 3'd4, 3'd1));
    set_imem(6, 16'hF000);
    start_prog();
    tick(10);
    check("alu_pc", {8'h00, dut.pc}, 16'h0006);
    check("alu_halted", 16'(dut.halted), 16'h0001);
    check("alu_r3", dut.regs[3], 16'h0008);
    check("alu_r4", dut.regs[4], 16'hFFFE);
    check("alu_r5", dut.regs[5], 16'h0001);
    $display("alu program: pc=%0h r3=%h r4=%h r5=%h", dut.pc, dut.regs[3], dut.regs[4], dut.regs[5]);

    // Reset while halted, restart, then reset again after a single edge.
    rst = 1'b1;
    tick(1);
    check("halt_rst_pc", {8'h00, dut.pc}, 16'h0000);
    check("halt_rst_halted", 16'(dut.halted), 16'h0000);
    rst = 1'b0;
    tick(1);
    check("restart_pc", {8'h00, dut.pc}, 16'h0001);
    rst = 1'b1;
    tick(1);
    check("rerst_pc", {8'h00, dut.pc}, 16'h0000);
    rst = 1'b0;
    $display("restart: pc=%0h", dut.pc);

    // Memory, R0 write discard and 16-bit wraparound.
    begin_prog();
    set_imem(0, enc_l(4'h8, 3'd1, 8'hAA));
    set_imem(1, enc_i(4'hA, 3'd1, 3'd0, 6'd4));
    set_imem(2, enc_i(4'h9, 3'd2, 3'd0, 6'd4));
    set_imem(3, enc_l(4'h8, 3'd0, 8'h55));
    set_imem(4, enc_i(4'h7, 3'd4, 3'd0, 6'h3F));
    set_imem(5, enc_i(4'h7, 3'd5, 3'd0, 6'd1));
    set_imem(6, enc_r(4'h1, 3'd6, 3'd4, 3'd5));
    set_imem(7, 16'hF000);
    start_prog();
    tick(10);
    check("mem_dmem4", dut.dmem[4], 16'h00AA);
    check("mem_r2", dut.regs[2], 16'h00AA);
    check("mem_r0", dut.regs[0], 16'h0000);
    check("mem_r4", dut.regs[4], 16'hFFFF);
    check("mem_r6", dut.regs[6], 16'h0000);
    $display("memory program: dmem[4]=%h r2=%h r6=%h", dut.dmem[4], dut.regs[2], dut.regs[6]);

    // Countdown loop followed by a BEQ on unequal operands.
    begin_prog();
    set_imem(0, enc_l(4'h8, 3'd1, 8'd3));
    set_imem(1, enc_i(4'h7, 3'd1, 3'd1, 6'h3F));
    set_imem(2, enc_i(4'hC, 3'd1, 3'd0, 6'h3E));
    set_imem(3, enc_l(4'h8, 3'd2, 8'd7));
    set_imem(4, enc_i(4'hB, 3'd2, 3'd1, 6'd2));
    set_imem(5, enc_l(4'h8, 3'd3, 8'd1));
    set_imem(6, 16'hF000);
    set_imem(7, enc_l(4'h8, 3'd3, 8'd2));
    set_imem(8, 16'hF000);
    start_prog();
    cyc = 0;
    while (!dut.halted && cyc < 50) begin
      tick(1);
      cyc++;
    end
    check("loop_cycles", 16'(cyc), 16'd11);
    check("loop_r1", dut.regs[1], 16'h0000);
    check("loop_r3", dut.regs[3], 16'h0001);
    check("loop_pc", {8'h00, dut.pc}, 16'h0006);
    $display("loop program: cycles=%0d r1=%h r3=%h", cyc, dut.regs[1], dut.regs[3]);

    // JMP to the last address, then pc wraps to zero.
    begin_prog();
    set_imem(0, {4'hD, 4'h0, 8'hFF});
    start_prog();
    tick(1);
    check("jmp_pc", {8'h00, dut.pc}, 16'h00FF);
    tick(1);
    check("wrap_pc", {8'h00, dut.pc}, 16'h0000);
    $display("jmp wrap: pc=%0h", dut.pc);

    // Random programs with occasional mid-run resets.
    for (int run = 0; run < 6; run++) begin
      begin_prog();
      for (int i = 0; i < 256; i++) begin
        w = 16'($urandom);
        if (w[15:12] == 4'hF && $urandom_range(0, 3) != 0) w[15:12] = 4'h1;
        if (w[15:12] >= 4'h1 && w[15:12] <= 4'h6) w[2:0] = 3'b000;
        set_imem(i, w);
      end
      start_prog();
      for (int c = 0; c < 300; c++) begin
        rst = ($urandom_range(0, 99) == 0);
        tick(1);
      end
      rst = 1'b0;
      for (int i = 0; i < 256; i++)
        check($sformatf("dmem%0d", i), dut.dmem[8'(i)], m_dmem[i]);
      $display("random run %0d: pc=%0h halted=%0d", run, dut.pc, dut.halted);
    end

    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
